// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM read arbiter.
//   state_e     : arbiter FSM states
//   AXI_DATA_W  : AXI read data width
//   ADDR_W_DEF  : default byte address width
//   BEAT_CNT_W  : beat counter width (matches the 8-bit AXI length)
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int unsigned AXI_DATA_W = 256;
    localparam int unsigned ADDR_W_DEF = 33;
    localparam int unsigned BEAT_CNT_W = 8;

endpackage

// File: rtl/dram_read_arbiter_rr_arbiter.sv
// Round-robin priority select: picks the first set request at or after ptr,
// searching circularly.
//   req  : request vector
//   ptr  : highest-priority index
//   gnt  : one-hot grant (zero when no request)
//   idx  : encoded grant index
//   any  : at least one request is set
module rr_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] pos;

    // Scan from the farthest offset to the nearest so the nearest set bit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = '0;
        any = |req;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr) + NUM_REQ - 1 - k) % NUM_REQ);
            if (req[pos]) begin
                idx = pos;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one 256-bit AXI read port between NUM_REQ requesters, one burst
// outstanding at a time, round-robin fairness.
// Optional build macro: DRAM_ARB_WATCHDOG_EN enables an idle-beat watchdog
// that aborts a stalled burst after TIMEOUT cycles and pulses err_out.
//   req_valid/req_addr/req_len : per-requester read requests (packed)
//   req_ready                  : one-hot accept pulse (IDLE cycle of grant)
//   rsp_valid/rsp_last/rsp_data: beat steering back to the owning requester
//   axi_ar*                    : AXI read address channel
//   axi_r*                     : AXI read data channel
//   err_out                    : watchdog abort pulse
// rsp_*, req_ready, axi_arvalid_out, axi_rready_out and err_out are decoded
// from the state register and live inputs; AR payload comes from latches.
module dram_read_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
`ifdef DRAM_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*8-1:0]        req_len,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_last,
    output logic [AXI_DATA_W-1:0]       rsp_data,
    output logic                        axi_arvalid_out,
    input  logic                        axi_arready_in,
    output logic [ID_W-1:0]             axi_arid_out,
    output logic [ADDR_W-1:0]           axi_araddr_out,
    output logic [7:0]                  axi_arlen_out,
    input  logic                        axi_rvalid_in,
    input  logic [ID_W-1:0]             axi_rid_in,
    input  logic [AXI_DATA_W-1:0]       axi_rdata_in,
    output logic                        axi_rready_out,
    output logic                        err_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BEAT_CNT_W-1:0] len_q, len_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;

    logic [ADDR_W-1:0]     addr_arr [NUM_REQ];
    logic [BEAT_CNT_W-1:0] len_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  rid_match;
    logic [IDX_W-1:0]      ptr_next;

    // Unpack the per-requester address/length fields.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = req_len[i*BEAT_CNT_W +: BEAT_CNT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign rid_match      = (axi_rid_in == ID_W'(gnt_idx_q));
    assign ptr_next       = IDX_W'((32'(gnt_idx_q) + 32'd1) % NUM_REQ);
    assign axi_arid_out   = ID_W'(gnt_idx_q);
    assign axi_araddr_out = addr_q;
    assign axi_arlen_out  = len_q;

`ifdef DRAM_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_c;
    assign err_out = err_c;

    // Idle-beat watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign err_out = 1'b0;
`endif

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
        end
    end

    // Next-state, grant latching and beat steering.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        gnt_idx_d       = gnt_idx_q;
        addr_d          = addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        req_ready       = '0;
        rsp_valid       = '0;
        rsp_last        = 1'b0;
        rsp_data        = '0;
        axi_arvalid_out = 1'b0;
        axi_rready_out  = 1'b0;
`ifdef DRAM_ARB_WATCHDOG_EN
        wdog_d          = '0;
        err_c           = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_idx_d = arb_idx;
                    addr_d    = addr_arr[arb_idx];
                    len_d     = len_arr[arb_idx];
                    req_ready = arb_gnt;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                axi_arvalid_out = 1'b1;
                if (axi_arready_in) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                axi_rready_out = 1'b1;
                rsp_data       = axi_rdata_in;
                // Beats for other IDs are accepted and dropped.
                if (axi_rvalid_in && rid_match) begin
                    rsp_valid[gnt_idx_q] = 1'b1;
                    beat_d               = beat_q + BEAT_CNT_W'(1);
                    if (beat_q == len_q) begin
                        rsp_last = 1'b1;
                        ptr_d    = ptr_next;
                        state_d  = ST_IDLE;
                    end
                end
`ifdef DRAM_ARB_WATCHDOG_EN
                if (axi_rvalid_in) begin
                    wdog_d = '0;
                end else if (32'(wdog_q) + 32'd1 >= TIMEOUT) begin
                    err_c   = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep every decoded output quiet while reset is applied.
        if (rst) begin
            req_ready       = '0;
            rsp_valid       = '0;
            rsp_last        = 1'b0;
            rsp_data        = '0;
            axi_arvalid_out = 1'b0;
            axi_rready_out  = 1'b0;
`ifdef DRAM_ARB_WATCHDOG_EN
            err_c           = 1'b0;
`endif
        end
    end

endmodule
